cpu_ctrl_fsm: RTL
=================

CPU_CTRL_FSM -- requirements
Module: cpu_ctrl_fsm

Interface
REQ-001 SHALL: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL: s  in  1  start; sampled only in WAIT.
REQ-004 SHALL: load  in  1  instruction-register load enable.
REQ-005 SHALL: in  in  16  instruction word.
REQ-006 SHALL: w  out  1  idle flag; 1 only in WAIT.
REQ-007 SHALL: readnum, writenum  out  3 each  register-file addresses.
REQ-008 SHALL: loada, loadb, loadc, loads, asel, bsel, write  out  1 each  datapath strobes and selects.
REQ-009 SHALL: vsel  out  2  writeback select (00 mdata, 01 sximm8, 10 PC, 11 C).
REQ-010 SHALL: shift, ALUop  out  2 each  shifter op; ALU op (00 add, 01 sub, 10 and, 11 not-B).
REQ-011 SHALL: sximm8, sximm5  out  16 each  sign-extended IR[7:0] and IR[4:0].
REQ-012 SHALL: err  out  1  illegal-instruction trap flag (see Configuration).

Function
REQ-013 SHALL: 16-bit IR loads `in` on any clock edge with load=1, in every state; decode and outputs use IR only, never `in`.
REQ-014 SHALL: IR fields opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0].
REQ-015 SHALL: states WAIT, DECODE, GET_A, GET_B, ALU, WR_REG, WR_IMM, ERR; Moore outputs; all strobes 0 unless listed.
REQ-016 SHALL: WAIT -> DECODE when s=1; else stay.
REQ-017 SHALL: DECODE routing: 110/10 (MOV imm) -> WR_IMM; 110/00 (MOV reg), 101/11 (MVN) -> GET_B; 101/00 (ADD), 101/01 (CMP), 101/10 (AND) -> GET_A; other -> illegal handling.
REQ-018 SHALL: GET_A: readnum=Rn, loada=1; -> GET_B.
REQ-019 SHALL: GET_B: readnum=Rm, loadb=1; -> ALU.
REQ-020 SHALL: ALU: shift=sh, bsel=0, asel=1 for MOV reg/MVN else 0; ALUop=00 MOV reg, else op; CMP: loads=1, loadc=0, -> WAIT; others: loadc=1, loads=0, -> WR_REG.
REQ-021 SHALL: WR_REG: writenum=Rd, vsel=11, write=1; -> WAIT.
REQ-022 SHALL: WR_IMM: writenum=Rn, vsel=01, write=1; -> WAIT.
REQ-023 SHALL: latency s-to-w: MOV imm 3 cycles, MOV reg/MVN 5, CMP 5, ADD/AND 6 (WAIT counted at return).
REQ-024 SHALL: s held high in WAIT after completion starts next instruction immediately; s ignored outside WAIT.
REQ-025 SHALL: load=1 during an executing instruction updates IR but fields used by later states change accordingly (software must not do this); no hazard protection.

Reset
REQ-026 SHALL: rst_n=0 forces WAIT, IR=0, w=1, err=0, all strobes and selects 0 immediately, including mid-instruction; no partial write completes.

Configuration
REQ-027 SHALL: with CPU_CTRL_ILLEGAL_TRAP_EN defined, illegal decode -> ERR; ERR holds err=1, w=0, all strobes 0, exits only by reset.
REQ-028 SHALL: without CPU_CTRL_ILLEGAL_TRAP_EN, illegal decode -> WAIT as NOP, err tied 0, ERR state absent.

Structure
REQ-029 SHALL: package cpu_ctrl_pkg holds state enum, opcode/op constants, vsel and ALUop encodings.
REQ-030 SHALL: one sub-module instr_decoder: IR -> fields, sximm8, sximm5, instruction class; FSM in cpu_ctrl_fsm.

Verification
REQ-031 SHALL: load 16'hD007 (MOV R0,#7), s pulse -> WR_IMM cycle writenum=0, vsel=01, write=1, sximm8=16'h0007; w=1 after 3 cycles.
REQ-032 SHALL: 16'hA148 (ADD R2,R1,R0,LSL#1) -> GET_A readnum=1 loada; GET_B readnum=0 loadb; ALU shift=01, asel=0, ALUop=00, loadc; WR_REG writenum=2, vsel=11.
REQ-033 SHALL: 16'hA900 (CMP R1,R0) -> ALU loads=1, loadc=0, ALUop=01; write never asserted; w=1 after 5 cycles.
REQ-034 SHALL: 16'hB860 (MVN R3,R0) -> GET_A skipped, ALU asel=1, ALUop=11; WR_REG writenum=3.
REQ-035 SHALL: rst_n low during ALU of 16'hA148 -> write never asserts, w=1 at once, IR=0.
REQ-036 SHALL: 16'hE000 with macro -> err=1 held until reset; without -> w=1 after 2 cycles, no strobes.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared types and constants for the CPU controller slice: FSM state enum,
// instruction-class enum, opcode/op field values, writeback-select and ALU
// operation encodings.
//
// Optional feature macro: CPU_CTRL_ILLEGAL_TRAP_EN
//   defined   -> the ERR state exists and illegal instructions trap there
//   undefined -> no ERR state; illegal instructions behave as a NOP
// ----------------------------------------------------------------------------
package cpu_ctrl_pkg;

    // Top-level opcode field IR[15:13]
    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    // Sub-operation field IR[12:11]
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    // Writeback data select
    localparam logic [1:0] VSEL_MDATA  = 2'b00;
    localparam logic [1:0] VSEL_SXIMM8 = 2'b01;
    localparam logic [1:0] VSEL_PC     = 2'b10;
    localparam logic [1:0] VSEL_C      = 2'b11;

    // ALU operation select
    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOTB = 2'b11;

    // Controller states; ERR only exists when illegal-instruction trapping is built in
    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_GET_A,
        S_GET_B,
        S_ALU,
        S_WR_REG,
        S_WR_IMM
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
        ,
        S_ERR
`endif
    } state_e;

    // Instruction classes recognised by the decoder
    typedef enum logic [2:0] {
        CLS_MOV_IMM,
        CLS_MOV_REG,
        CLS_MVN,
        CLS_ADD,
        CLS_CMP,
        CLS_AND,
        CLS_ILLEGAL
    } instr_class_e;

    // Map the opcode/op pair onto an instruction class
    function automatic instr_class_e classify(input logic [2:0] opcode, input logic [1:0] op);
        instr_class_e cls;
        cls = CLS_ILLEGAL;
        if (opcode == OPC_MOV) begin
            if (op == OP_MOV_IMM) cls = CLS_MOV_IMM;
            else if (op == OP_MOV_REG) cls = CLS_MOV_REG;
        end else if (opcode == OPC_ALU) begin
            case (op)
                OP_ADD:  cls = CLS_ADD;
                OP_CMP:  cls = CLS_CMP;
                OP_AND:  cls = CLS_AND;
                default: cls = CLS_MVN;
            endcase
        end
        return cls;
    endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// ----------------------------------------------------------------------------
// cpu_ctrl_if
// Bundles the controller's instruction input and datapath control outputs.
//   master : issues start/load/instruction word, observes the control outputs
//   slave  : the controller itself
// Signals:
//   s, load, in[15:0]            start, IR load enable, instruction word
//   w, err                       idle flag, illegal-instruction trap flag
//   readnum, writenum [2:0]      register-file addresses
//   loada, loadb, loadc, loads   datapath register load strobes
//   asel, bsel, write            operand selects, register-file write
//   vsel, shift, ALUop [1:0]     writeback select, shifter op, ALU op
//   sximm8, sximm5 [15:0]        sign-extended immediates from the IR
// ----------------------------------------------------------------------------
interface cpu_ctrl_if;

    logic        s;
    logic        load;
    logic [15:0] in;
    logic        w;
    logic        err;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic        write;
    logic [1:0]  vsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic [15:0] sximm8;
    logic [15:0] sximm5;

    modport master (
        output s, load, in,
        input  w, err, readnum, writenum, loada, loadb, loadc, loads,
               asel, bsel, write, vsel, shift, ALUop, sximm8, sximm5
    );

    modport slave (
        input  s, load, in,
        output w, err, readnum, writenum, loada, loadb, loadc, loads,
               asel, bsel, write, vsel, shift, ALUop, sximm8, sximm5
    );

endinterface

// File: rtl/cpu_ctrl_fsm_instr_decoder.sv
// ----------------------------------------------------------------------------
// instr_decoder
// Purely combinational split of the instruction register into its fields,
// sign-extended immediates and an instruction class for the controller FSM.
// Ports:
//   i_ir[15:0]                 instruction register contents
//   o_op[1:0]                  IR[12:11]
//   o_rn, o_rd, o_rm [2:0]     IR[10:8], IR[7:5], IR[2:0]
//   o_sh[1:0]                  IR[4:3]
//   o_sximm8, o_sximm5 [15:0]  sign-extended IR[7:0] and IR[4:0]
//   o_class                    decoded instruction class
// ----------------------------------------------------------------------------
module instr_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [15:0]  i_ir,
    output logic [1:0]   o_op,
    output logic [2:0]   o_rn,
    output logic [2:0]   o_rd,
    output logic [1:0]   o_sh,
    output logic [2:0]   o_rm,
    output logic [15:0]  o_sximm8,
    output logic [15:0]  o_sximm5,
    output instr_class_e o_class
);

    assign o_op     = i_ir[12:11];
    assign o_rn     = i_ir[10:8];
    assign o_rd     = i_ir[7:5];
    assign o_sh     = i_ir[4:3];
    assign o_rm     = i_ir[2:0];
    assign o_sximm8 = {{8{i_ir[7]}}, i_ir[7:0]};
    assign o_sximm5 = {{11{i_ir[4]}}, i_ir[4:0]};

    // Class depends only on opcode and op; everything else is operand data
    always_comb begin
        o_class = classify(i_ir[15:13], i_ir[12:11]);
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// cpu_ctrl_fsm
// Multi-cycle controller for a simple register-file/ALU datapath. An
// instruction is latched into the IR whenever load=1; a start pulse in WAIT
// walks it through DECODE and the operand/execute/writeback states. All
// control outputs are Moore outputs of the current state and the IR.
// Ports:
//   clk    sole clock, rising edge
//   rst_n  asynchronous active-low reset (returns to WAIT, clears IR)
//   bus    cpu_ctrl_if.slave: s/load/in inputs, datapath control outputs
// Optional feature macro: CPU_CTRL_ILLEGAL_TRAP_EN
//   defined   -> illegal instructions enter ERR (err=1) until reset
//   undefined -> illegal instructions return to WAIT as a NOP, err tied 0
// ----------------------------------------------------------------------------
module cpu_ctrl_fsm
    import cpu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    cpu_ctrl_if.slave   bus
);

    logic [15:0]  r_ir;
    state_e       r_state;
    state_e       w_next;

    logic [1:0]   w_op;
    logic [2:0]   w_rn;
    logic [2:0]   w_rd;
    logic [1:0]   w_sh;
    logic [2:0]   w_rm;
    logic [15:0]  w_sximm8;
    logic [15:0]  w_sximm5;
    instr_class_e w_class;

    instr_decoder u_decoder (
        .i_ir     (r_ir),
        .o_op     (w_op),
        .o_rn     (w_rn),
        .o_rd     (w_rd),
        .o_sh     (w_sh),
        .o_rm     (w_rm),
        .o_sximm8 (w_sximm8),
        .o_sximm5 (w_sximm5),
        .o_class  (w_class)
    );

    assign bus.sximm8 = w_sximm8;
    assign bus.sximm5 = w_sximm5;

    // IR loads in every state; no protection against reloading mid-instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ir <= '0;
        end else if (bus.load) begin
            r_ir <= bus.in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_WAIT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_WAIT: begin
                if (bus.s) w_next = S_DECODE;
            end
            S_DECODE: begin
                case (w_class)
                    CLS_MOV_IMM:                 w_next = S_WR_IMM;
                    CLS_MOV_REG, CLS_MVN:        w_next = S_GET_B;
                    CLS_ADD, CLS_CMP, CLS_AND:   w_next = S_GET_A;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
                    default:                     w_next = S_ERR;
`else
                    default:                     w_next = S_WAIT;
`endif
                endcase
            end
            S_GET_A:  w_next = S_GET_B;
            S_GET_B:  w_next = S_ALU;
            // CMP only updates status flags, so it has no writeback cycle
            S_ALU:    w_next = (w_class == CLS_CMP) ? S_WAIT : S_WR_REG;
            S_WR_REG: w_next = S_WAIT;
            S_WR_IMM: w_next = S_WAIT;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
            S_ERR:    w_next = S_ERR;
`endif
            default:  w_next = S_WAIT;
        endcase
    end

    always_comb begin
        bus.w        = 1'b0;
        bus.readnum  = 3'd0;
        bus.writenum = 3'd0;
        bus.loada    = 1'b0;
        bus.loadb    = 1'b0;
        bus.loadc    = 1'b0;
        bus.loads    = 1'b0;
        bus.asel     = 1'b0;
        bus.bsel     = 1'b0;
        bus.write    = 1'b0;
        bus.vsel     = VSEL_MDATA;
        bus.shift    = 2'b00;
        bus.ALUop    = ALU_ADD;
        case (r_state)
            S_WAIT: begin
                bus.w = 1'b1;
            end
            S_GET_A: begin
                bus.readnum = w_rn;
                bus.loada   = 1'b1;
            end
            S_GET_B: begin
                bus.readnum = w_rm;
                bus.loadb   = 1'b1;
            end
            S_ALU: begin
                bus.shift = w_sh;
                // Single-operand moves zero the A side so the ALU passes B through
                bus.asel  = (w_class == CLS_MOV_REG) || (w_class == CLS_MVN);
                bus.ALUop = (w_class == CLS_MOV_REG) ? ALU_ADD : w_op;
                if (w_class == CLS_CMP) begin
                    bus.loads = 1'b1;
                end else begin
                    bus.loadc = 1'b1;
                end
            end
            S_WR_REG: begin
                bus.writenum = w_rd;
                bus.vsel     = VSEL_C;
                bus.write    = 1'b1;
            end
            S_WR_IMM: begin
                bus.writenum = w_rn;
                bus.vsel     = VSEL_SXIMM8;
                bus.write    = 1'b1;
            end
            default: begin
            end
        endcase
    end

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    assign bus.err = (r_state == S_ERR);
`else
    assign bus.err = 1'b0;
`endif

endmodule
